pipelined_adder: RTL and testbench

- Parametrised, pipelined successor to the team's combinational adder cells.
- Adds two WIDTH-bit operands plus a carry-in by splitting them into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Uses a valid/ready handshake on both sides.
- Sits between operand registers and the datapath accumulator in the arithmetic unit, where a full-width ripple carry would miss timing.

---
 rtl/arith_pkg.sv | 18 +
 rtl/adder_slice.sv | 21 ++
 rtl/pipelined_adder.sv | 107 ++++++++++
 tb/tb_pipelined_adder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic helpers: pipeline depth, configuration legality and the
// signed-overflow rule used by the pipelined adder family.
package arith_pkg;

    function automatic int stages_of(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    function automatic bit cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    // Signed overflow: carry into the MSB disagrees with the carry out of it.
    function automatic logic ovf_of(input logic c_msb, input logic c_out);
        return c_msb ^ c_out;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit add with carry-in; also reports the carry into the
// slice MSB so the last stage can derive signed overflow.
module adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum   = total[CHUNK-1:0];
    assign cout  = total[CHUNK];
    assign cmsb  = a[CHUNK-1] ^ b[CHUNK-1] ^ total[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into CHUNK-bit stages with registered carries and a
// whole-pipe valid/ready stall; one result per cycle when unstalled.
module pipelined_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stages_of(WIDTH, CHUNK);

    generate
        if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
            $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    logic              advance;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic              ovf_q;
    logic [WIDTH-1:0]  a_q    [STAGES];
    logic [WIDTH-1:0]  b_q    [STAGES];
    logic [WIDTH-1:0]  sum_q  [STAGES];

    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_out;
    logic              c_msb   [STAGES];
    logic [WIDTH-1:0]  a_in    [STAGES];
    logic [WIDTH-1:0]  b_in    [STAGES];
    logic [WIDTH-1:0]  sum_in  [STAGES];
    logic [WIDTH-1:0]  sum_nx  [STAGES];
    logic [CHUNK-1:0]  s_slice [STAGES];

    // Operands are pre-shifted so every stage consumes the low CHUNK bits;
    // finished sum slices accumulate in place as they move forward.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in[k]   = a;
            assign b_in[k]   = b;
            assign c_in[k]   = cin;
            assign v_in[k]   = in_valid;
            assign sum_in[k] = '0;
        end else begin : g_body
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign c_in[k]   = carry_q[k-1];
            assign v_in[k]   = valid_q[k-1];
            assign sum_in[k] = sum_q[k-1];
        end

        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a    (a_in[k][CHUNK-1:0]),
            .b    (b_in[k][CHUNK-1:0]),
            .cin  (c_in[k]),
            .sum  (s_slice[k]),
            .cout (c_out[k]),
            .cmsb (c_msb[k])
        );

        assign sum_nx[k] = sum_in[k] | (WIDTH'(s_slice[k]) << (k * CHUNK));
    end

    assign advance   = !valid_q[STAGES-1] || out_ready;
    assign in_ready  = rst_n && advance;
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= v_in;
            carry_q <= c_out;
            ovf_q   <= ovf_of(c_msb[STAGES-1], c_out[STAGES-1]);
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_in[k] >> CHUNK;
                b_q[k]   <= b_in[k] >> CHUNK;
                sum_q[k] <= sum_nx[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder at WIDTH=16, CHUNK=4: expected results
// are queued on input transfer and compared on output transfer.
module tb_pipelined_adder;

    localparam int W = 16;
    localparam int C = 4;
    localparam int S = W / C;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic [31:0]  acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b1;

    pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid === 1'b1 && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'(sum), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.co));
                chk("ovf", 32'(ovf), 32'(e.ov));
                if (lat_chk) chk("latency", 32'(cyc) - e.acc, 32'(S));
                n_out++;
            end
        end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = cv;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_t e;
                logic [W:0] tot;
                tot  = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
                e.s  = tot[W-1:0];
                e.co = tot[W];
                e.ov = (av[W-1] == bv[W-1]) && (tot[W-1] != av[W-1]);
                e.acc = 32'(cyc);
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && q.size() != 0; t++) @(negedge clk);
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'(0));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        // reset held with a pending input
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 16'hAAAA;
        b = 16'h5555;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", 32'(out_valid), 32'(0));
            chk("rst_sum", 32'(sum), 32'(0));
            chk("rst_cout", 32'(cout), 32'(0));
            chk("rst_ovf", 32'(ovf), 32'(0));
            chk("rst_in_ready", 32'(in_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;

        // single op and carry/overflow corners
        base = n_out;
        send(16'h00FF, 16'h0001, 1'b0);
        drain();
        send(16'hFFFF, 16'h0000, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0);
        drain();
        chk("single_and_corner_count", 32'(n_out - base), 32'(3));

        // back-to-back streaming
        base = n_out;
        for (int i = 0; i < 8; i++) send(W'(i), W'(i) << 8, i[0]);
        drain();
        chk("stream_count", 32'(n_out - base), 32'(8));

        // backpressure while streaming
        base = n_out;
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(16'h0101 * W'(i + 1), 16'h00F0 + W'(i), i[0]);
            end
            begin
                bit seen;
                logic [W-1:0] held;
                seen = 1'b0;
                for (int t = 0; t < 60 && !seen; t++) begin
                    @(negedge clk);
                    if (out_valid) seen = 1'b1;
                end
                if (!seen) begin
                    chk("bp_wait_timeout", 32'(0), 32'(1));
                end else begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'b0;
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready), 32'(0));
                    held = sum;
                    repeat (2) begin
                        @(negedge clk);
                        chk("bp_in_ready", 32'(in_ready), 32'(0));
                        chk("bp_sum_held", 32'(sum), 32'(held));
                        chk("bp_valid_held", 32'(out_valid), 32'(1));
                    end
                    @(posedge clk);
                    #1;
                    out_ready = 1'b1;
                end
            end
        join
        drain();
        lat_chk = 1'b1;
        chk("bp_count", 32'(n_out - base), 32'(6));

        // reset with operations in flight
        send(16'h1111, 16'h2222, 1'b0);
        send(16'h3333, 16'h4444, 1'b1);
        send(16'h5555, 16'h6666, 1'b0);
        rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = n_out;
        send(16'h1234, 16'h1111, 1'b0);
        drain();
        repeat (6) @(negedge clk);
        chk("rst_mid_count", 32'(n_out - base), 32'(1));
        chk("rst_mid_last_sum", 32'(sum), 32'h2345);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
